// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word load or store at a time and
// drives a simple word-wide memory port. Sub-word stores do a read-modify-write.
// Optional feature macro: LSU_ALIGN_CHECK_EN (misaligned half/word -> error).
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_i,
  input  logic [31:0] mem_data_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] store_word;

  // Decode whether an incoming request must be answered with an error
  always_comb begin
    req_err = (req_op[1:0] == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
    if (req_op[1:0] == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_op[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
`endif
  end

  // Extract and extend the addressed byte/half from the read word
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = '0;
    h = '0;
    case (addr_q[1:0])
      2'b00:   b = mem_data_o[7:0];
      2'b01:   b = mem_data_o[15:8];
      2'b10:   b = mem_data_o[23:16];
      default: b = mem_data_o[31:24];
    endcase
    h = addr_q[1] ? mem_data_o[31:16] : mem_data_o[15:0];
    case (op_q[1:0])
      2'b00:   load_val = op_q[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_val = op_q[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_val = mem_data_o;
    endcase
  end

  // Merge store data into the captured word (read-modify-write for sub-word)
  always_comb begin
    store_word = word_q;
    case (op_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'b00:   store_word[7:0]   = wdata_q[7:0];
          2'b01:   store_word[15:8]  = wdata_q[7:0];
          2'b10:   store_word[23:16] = wdata_q[7:0];
          default: store_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1])
          store_word[31:16] = wdata_q[15:0];
        else
          store_word[15:0]  = wdata_q[15:0];
      end
      default: store_word = wdata_q;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)
            state_d = S_RESP;
          else if (req_op[3] && req_op[1:0] == 2'b10)
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
        word_d = mem_data_o;
        if (op_q[3]) begin
          state_d = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        state_d = S_RESP;
      end
      default: begin
        if (resp_ready)
          state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from the registered state only
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    resp_err   = (state_q == S_RESP) ? err_q : 1'b0;
    mem_ren    = (state_q == S_RD);
    mem_wen    = (state_q == S_WR);
    mem_addr   = (state_q == S_RD || state_q == S_WR) ? {addr_q[31:2], 2'b00} : '0;
    mem_data_i = (state_q == S_WR) ? store_word : '0;
  end

endmodule
